// File: rtl/psum_accum_buffer_if.sv
// psum_accum_buffer_if
//   Bundles the job-control, upstream fill and downstream drain signals of the
//   partial-sum accumulation buffer. Clock and reset stay outside as plain ports.
//   slave  : the buffer side (psum_accum_buffer)
//   master : the controller / upstream / downstream side (e.g. a testbench)
//   Signals:
//     start_i, num_psums_i, passes_i   job request and its configuration
//     enable_i, data_i, ready_o        upstream psum handshake
//     enable_o, data_o, ready_i        downstream drain handshake
//     busy_o, done_o                   job status
interface psum_accum_buffer_if #(
  parameter int DATA_BITWIDTH = 20,
  parameter int ADDR_BITWIDTH = 4
);
  logic                     start_i;
  logic [ADDR_BITWIDTH:0]   num_psums_i;
  logic [3:0]               passes_i;
  logic                     enable_i;
  logic [DATA_BITWIDTH-1:0] data_i;
  logic                     ready_o;
  logic                     enable_o;
  logic [DATA_BITWIDTH-1:0] data_o;
  logic                     ready_i;
  logic                     busy_o;
  logic                     done_o;

  modport slave (
    input  start_i, num_psums_i, passes_i, enable_i, data_i, ready_i,
    output ready_o, enable_o, data_o, busy_o, done_o
  );

  modport master (
    output start_i, num_psums_i, passes_i, enable_i, data_i, ready_i,
    input  ready_o, enable_o, data_o, busy_o, done_o
  );
endinterface

// File: rtl/psum_accum_buffer.sv
// psum_accum_buffer
//   Holds up to DEPTH partial sums. A job fills num_psums entries, then adds
//   (passes-1) further rounds of psums onto them with saturating arithmetic,
//   and finally drains the accumulated entries in address order.
//   Ports:
//     clk_i  : clock, all state on rising edge
//     rst_ni : asynchronous active-low reset
//     bus    : slave modport of psum_accum_buffer_if (control, fill, drain, status)
//   DEPTH must equal 2**ADDR_BITWIDTH.
module psum_accum_buffer #(
  parameter int DATA_BITWIDTH = 20,
  parameter int DEPTH         = 16,
  parameter int ADDR_BITWIDTH = 4
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  psum_accum_buffer_if.slave  bus
);

  localparam int DW = DATA_BITWIDTH;
  localparam logic [ADDR_BITWIDTH:0] NUM_ONE = (ADDR_BITWIDTH+1)'(1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t state, state_nxt;

  logic [DW-1:0]            mem [DEPTH];
  logic [ADDR_BITWIDTH-1:0] wr_addr, rd_addr;
  logic [3:0]               pass_cnt, passes_q;
  logic [ADDR_BITWIDTH:0]   num_q;
  logic                     done_q;

  logic          start_ok, start_nop;
  logic          fill_xfer, drain_xfer;
  logic          last_entry, last_pass, last_rd;
  logic [DW:0]   sum;
  logic [DW-1:0] sat_val, wr_data, rd_data;

  // Degenerate jobs (nothing to fill or no passes) complete immediately.
  assign start_ok  = (state == IDLE) && bus.start_i &&
                     (bus.num_psums_i != '0) && (bus.passes_i != '0);
  assign start_nop = (state == IDLE) && bus.start_i &&
                     ((bus.num_psums_i == '0) || (bus.passes_i == '0));

  assign fill_xfer  = (state == FILL)  && bus.enable_i;
  assign drain_xfer = (state == DRAIN) && bus.ready_i;

  assign last_entry = ({1'b0, wr_addr} == (num_q - NUM_ONE));
  assign last_pass  = (pass_cnt == (passes_q - 4'd1));
  assign last_rd    = ({1'b0, rd_addr} == (num_q - NUM_ONE));

  // Sign-extended add one bit wider; overflow shows as top two bits differing,
  // and the top bit then tells which rail to clamp to.
  assign sum     = {mem[wr_addr][DW-1], mem[wr_addr]} + {bus.data_i[DW-1], bus.data_i};
  assign sat_val = (sum[DW] != sum[DW-1]) ?
                   (sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}}) :
                   sum[DW-1:0];
  assign wr_data = (pass_cnt == '0) ? bus.data_i : sat_val;
  assign rd_data = mem[rd_addr];

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = FILL;
      FILL:    if (fill_xfer && last_entry && last_pass) state_nxt = DRAIN;
      DRAIN:   if (drain_xfer && last_rd) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs, all decoded from state except the registered done pulse
  always_comb begin
    bus.ready_o  = (state == FILL);
    bus.enable_o = (state == DRAIN);
    bus.busy_o   = (state != IDLE);
    bus.data_o   = (state == DRAIN) ? rd_data : '0;
    bus.done_o   = done_q;
  end

  // Address / pass counters, latched config, done pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      pass_cnt <= '0;
      num_q    <= '0;
      passes_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= start_nop || (drain_xfer && last_rd);
      if (start_ok) begin
        num_q    <= bus.num_psums_i;
        passes_q <= bus.passes_i;
        wr_addr  <= '0;
        pass_cnt <= '0;
      end
      if (fill_xfer) begin
        if (last_entry) begin
          wr_addr  <= '0;
          pass_cnt <= pass_cnt + 4'd1;
          if (last_pass) rd_addr <= '0;
        end else begin
          wr_addr <= wr_addr + 1'b1;
        end
      end
      if (drain_xfer) rd_addr <= rd_addr + 1'b1;
    end
  end

  // Entry storage has no reset: the first pass always overwrites.
  always_ff @(posedge clk_i) begin
    if (fill_xfer) mem[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_psum_accum_buffer.sv
// tb_psum_accum_buffer
//   Randomized and directed jobs against a queue/array reference model of the
//   accumulate-then-drain behaviour. Inputs driven and outputs sampled on the
//   falling clock edge.
module tb_psum_accum_buffer;
  localparam int DW   = 20;
  localparam int MAXV = (1 << (DW-1)) - 1;
  localparam int MINV = -(1 << (DW-1));

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  psum_accum_buffer_if #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(4)) bus ();

  psum_accum_buffer #(.DATA_BITWIDTH(DW), .DEPTH(16), .ADDR_BITWIDTH(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int pushes[$];
  int expd[16];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int s);
    if (s > MAXV) return MAXV;
    if (s < MINV) return MINV;
    return s;
  endfunction

  function automatic int dout();
    return int'($signed(bus.data_o));
  endfunction

  task automatic check_quiet(input string tag);
    chk({tag, "_ready"}, int'(bus.ready_o), 0);
    chk({tag, "_enable"}, int'(bus.enable_o), 0);
    chk({tag, "_data"}, dout(), 0);
    chk({tag, "_busy"}, int'(bus.busy_o), 0);
    chk({tag, "_done"}, int'(bus.done_o), 0);
  endtask

  // Runs one job with the psums currently in 'pushes' (num*passes values).
  task automatic run_job(input int num, input int passes, input bit gaps,
                         input int stall_pct, input int stall_at, input bit start_in_fill);
    int idx, cyc, hold;
    bit rdy;
    // Reference: push k lands on entry k%num in pass k/num.
    for (int k = 0; k < pushes.size(); k++) begin
      if (k / num == 0) expd[k % num] = pushes[k];
      else              expd[k % num] = sat(expd[k % num] + pushes[k]);
    end

    @(negedge clk);
    bus.start_i     = 1'b1;
    bus.num_psums_i = 5'(num);
    bus.passes_i    = 4'(passes);
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("busy_fill", int'(bus.busy_o), 1);
    chk("ready_fill", int'(bus.ready_o), 1);

    for (int k = 0; k < pushes.size(); k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.enable_i = 1'b0;
        bus.data_i   = DW'($urandom);
        @(negedge clk);
        chk("ready_gap", int'(bus.ready_o), 1);
      end
      bus.enable_i = 1'b1;
      bus.data_i   = DW'(pushes[k]);
      if (start_in_fill && k == 0) begin
        bus.start_i     = 1'b1;
        bus.num_psums_i = 5'd1;
        bus.passes_i    = 4'd1;
      end
      @(negedge clk);
      bus.start_i = 1'b0;
      if (k != pushes.size() - 1) chk("ready_mid", int'(bus.ready_o), 1);
    end
    bus.enable_i = 1'b0;
    chk("fill2drain_en", int'(bus.enable_o), 1);
    chk("fill2drain_rdy", int'(bus.ready_o), 0);

    idx = 0; cyc = 0; hold = 0;
    while (idx < num && cyc < 400) begin
      chk("drain_vld", int'(bus.enable_o), 1);
      chk("drain_data", dout(), expd[idx]);
      if (idx == stall_at && hold < 3) begin
        rdy = 1'b0;
        hold++;
      end else begin
        rdy = ($urandom_range(0, 99) >= stall_pct);
      end
      bus.ready_i  = rdy;
      // upstream noise while not ready must be dropped
      bus.enable_i = 1'($urandom_range(0, 1));
      bus.data_i   = DW'($urandom);
      @(negedge clk);
      if (rdy) idx++;
      cyc++;
    end
    chk("drain_count", idx, num);
    bus.ready_i  = 1'b1;
    bus.enable_i = 1'b0;
    chk("done_pulse", int'(bus.done_o), 1);
    chk("done_busy", int'(bus.busy_o), 0);
    chk("done_enable", int'(bus.enable_o), 0);
    chk("done_data", dout(), 0);
    @(negedge clk);
    chk("done_single", int'(bus.done_o), 0);
  endtask

  task automatic zero_start(input int num, input int passes);
    @(negedge clk);
    bus.start_i     = 1'b1;
    bus.num_psums_i = 5'(num);
    bus.passes_i    = 4'(passes);
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("zero_done", int'(bus.done_o), 1);
    chk("zero_busy", int'(bus.busy_o), 0);
    chk("zero_ready", int'(bus.ready_o), 0);
    @(negedge clk);
    chk("zero_done_off", int'(bus.done_o), 0);
    chk("zero_busy_off", int'(bus.busy_o), 0);
  endtask

  initial begin
    int num, passes, v;
    bus.start_i     = 1'b0;
    bus.num_psums_i = '0;
    bus.passes_i    = '0;
    bus.enable_i    = 1'b0;
    bus.data_i      = '0;
    bus.ready_i     = 1'b1;

    repeat (3) @(negedge clk);
    check_quiet("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("rst_release");

    // Simple single pass, back-to-back
    pushes = '{1, 2, 3, 4};
    run_job(4, 1, 1'b0, 0, -1, 1'b0);

    // Three passes over two entries: 10+7-3=14, -5+5+1=1
    pushes = '{10, -5, 7, 5, -3, 1};
    run_job(2, 3, 1'b0, 0, -1, 1'b0);

    // Saturation at both rails
    pushes = '{MAXV, 10};
    run_job(1, 2, 1'b0, 0, -1, 1'b0);
    pushes = '{MINV, -1};
    run_job(1, 2, 1'b0, 0, -1, 1'b0);

    // 3-cycle drain stall mid-stream
    pushes = {};
    for (int k = 0; k < 16; k++) pushes.push_back(k * 3 - 7);
    run_job(8, 2, 1'b0, 0, 3, 1'b0);

    // Degenerate starts, then a start issued during FILL
    zero_start(0, 3);
    zero_start(5, 0);
    pushes = {};
    for (int k = 0; k < 6; k++) pushes.push_back(100 + k);
    run_job(3, 2, 1'b0, 0, -1, 1'b1);

    // Reset in the middle of a fill after 2 of 4 pushes
    @(negedge clk);
    bus.start_i     = 1'b1;
    bus.num_psums_i = 5'd4;
    bus.passes_i    = 4'd1;
    @(negedge clk);
    bus.start_i  = 1'b0;
    bus.enable_i = 1'b1;
    bus.data_i   = DW'(111);
    @(negedge clk);
    bus.data_i   = DW'(222);
    @(negedge clk);
    bus.enable_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check_quiet("rst_mid_async");
    @(negedge clk);
    check_quiet("rst_mid_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("rst_mid_after");
    @(negedge clk);
    chk("rst_no_done", int'(bus.done_o), 0);
    pushes = '{7, -9};
    run_job(2, 1, 1'b0, 0, -1, 1'b0);

    // Full depth
    pushes = {};
    for (int k = 0; k < 32; k++) pushes.push_back(int'($urandom_range(0, 2000)) - 1000);
    run_job(16, 2, 1'b0, 20, -1, 1'b0);

    // Random jobs with gaps, stalls, and values spread over the full range
    for (int j = 0; j < 20; j++) begin
      num    = $urandom_range(1, 16);
      passes = $urandom_range(1, 4);
      pushes = {};
      for (int k = 0; k < num * passes; k++) begin
        if ($urandom_range(0, 1) == 0) v = int'($urandom_range(0, 2 * MAXV + 1)) + MINV;
        else                           v = int'($urandom_range(0, 200)) - 100;
        pushes.push_back(v);
      end
      run_job(num, passes, 1'b1, 30, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
